// File: rtl/riscv_core_pkg.sv
// Shared core types: register address width, register address type, multiplier occupancy states.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package riscv_core_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/mul_occupancy_fsm.sv
// Tracks how long a multi-cycle MUL keeps E occupied after it issues.
// Latency: busy_o rises the cycle after start_i and stays high for MUL_LAT-1 cycles.
// Backpressure: the owner must not assert start_i while busy_o is high; start_i is ignored in BUSY.
module mul_occupancy_fsm
  import riscv_core_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset abandons any MUL in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count down the extra E cycles, returning to IDLE after the cnt==1 cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        busy_o = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = MUL_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MUL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-side hazard control: scoreboards long-latency writers and stalls D / bubbles E on unresolved sources.
// Latency: stall_d/bubble_e are combinational from inputs and state; scoreboard and MUL state update on rising clk.
// Backpressure: stall_d holds F/D while a source is pending or the multiplier occupies E.
module hazard_scoreboard_unit
  import riscv_core_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int MUL_LAT  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid_d,
  input  logic [ADDR_W-1:0]   reg_readaddress1_d,
  input  logic [ADDR_W-1:0]   reg_readaddress2_d,
  input  logic                rs1_used_d,
  input  logic                rs2_used_d,
  input  logic                reg_write_d,
  input  logic [ADDR_W-1:0]   reg_writeaddress_d,
  input  logic                is_load_d,
  input  logic                is_mul_d,
  input  logic                wb_valid_w,
  input  logic [ADDR_W-1:0]   reg_writeaddress_w,
  input  logic                flush_e,
  output logic                stall_d,
  output logic                bubble_e,
  output logic                mul_busy_e,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                haz_1, haz_2, src_haz;
  logic                issue_ok, sb_set, mul_start;

  // Source compare: a pending source is fine if W writes it this very cycle (write-first RF).
  always_comb begin
    haz_1 = rs1_used_d && (reg_readaddress1_d != '0) && pend_q[reg_readaddress1_d]
            && !(wb_valid_w && (reg_writeaddress_w == reg_readaddress1_d));
    haz_2 = rs2_used_d && (reg_readaddress2_d != '0) && pend_q[reg_readaddress2_d]
            && !(wb_valid_w && (reg_writeaddress_w == reg_readaddress2_d));
    src_haz   = issue_valid_d && (haz_1 || haz_2);
    stall_d   = src_haz || mul_busy_e;
    bubble_e  = src_haz && !mul_busy_e;
    issue_ok  = issue_valid_d && !stall_d && !flush_e;
    sb_set    = issue_ok && reg_write_d && (reg_writeaddress_d != '0) && (is_load_d || is_mul_d);
    mul_start = issue_ok && is_mul_d;
  end

  // Scoreboard next value: clear on writeback first so a same-register issue overrides it.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid_w) begin
      pend_d[reg_writeaddress_w] = 1'b0;
    end
    if (sb_set) begin
      pend_d[reg_writeaddress_d] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

  mul_occupancy_fsm #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .busy_o  (mul_busy_e)
  );

  // A taken branch cannot sit in E while a MUL occupies it.
  a_no_flush_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) !(flush_e && mul_busy_e)
  );

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;
  import riscv_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_d;
  reg_addr_t   reg_readaddress1_d, reg_readaddress2_d;
  logic        rs1_used_d, rs2_used_d;
  logic        reg_write_d;
  reg_addr_t   reg_writeaddress_d;
  logic        is_load_d, is_mul_d;
  logic        wb_valid_w;
  reg_addr_t   reg_writeaddress_w;
  logic        flush_e;
  logic        stall_d, bubble_e, mul_busy_e;
  logic [31:0] pending_o;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard_unit #(.NUM_REGS(32), .ADDR_W(5), .MUL_LAT(3)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .issue_valid_d      (issue_valid_d),
    .reg_readaddress1_d (reg_readaddress1_d),
    .reg_readaddress2_d (reg_readaddress2_d),
    .rs1_used_d         (rs1_used_d),
    .rs2_used_d         (rs2_used_d),
    .reg_write_d        (reg_write_d),
    .reg_writeaddress_d (reg_writeaddress_d),
    .is_load_d          (is_load_d),
    .is_mul_d           (is_mul_d),
    .wb_valid_w         (wb_valid_w),
    .reg_writeaddress_w (reg_writeaddress_w),
    .flush_e            (flush_e),
    .stall_d            (stall_d),
    .bubble_e           (bubble_e),
    .mul_busy_e         (mul_busy_e),
    .pending_o          (pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    issue_valid_d = 0; reg_readaddress1_d = 0; reg_readaddress2_d = 0;
    rs1_used_d = 0; rs2_used_d = 0; reg_write_d = 0; reg_writeaddress_d = 0;
    is_load_d = 0; is_mul_d = 0; wb_valid_w = 0; reg_writeaddress_w = 0; flush_e = 0;
  endtask

  // D instruction: rd, load, mul, rs1 (used if nonzero flag), rs2
  task automatic d_instr(input logic wr, input logic [4:0] rd, input logic ld, input logic ml,
                         input logic u1, input logic [4:0] a1, input logic u2, input logic [4:0] a2);
    issue_valid_d = 1; reg_write_d = wr; reg_writeaddress_d = rd;
    is_load_d = ld; is_mul_d = ml;
    rs1_used_d = u1; reg_readaddress1_d = a1; rs2_used_d = u2; reg_readaddress2_d = a2;
  endtask

  task automatic wb(input logic v, input logic [4:0] a);
    wb_valid_w = v; reg_writeaddress_w = a;
  endtask

  // Advance to just after the next rising edge, then let inputs be re-driven.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    #2;
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_stall", {31'b0, stall_d}, 32'h0);
    chk("rst_bubble", {31'b0, bubble_e}, 32'h0);
    chk("rst_busy", {31'b0, mul_busy_e}, 32'h0);
    #10 rst_n = 1;
    tick();

    // 1. load-use
    d_instr(1, 5, 1, 0, 0, 0, 0, 0);          // lw x5
    #1 chk("lw5_issue_stall", {31'b0, stall_d}, 32'h0);
    tick();
    chk("lw5_pending", pending_o, 32'h20);
    d_instr(1, 6, 0, 0, 1, 5, 0, 0);          // add x6, x5
    #1 chk("lu_stall", {31'b0, stall_d}, 32'h1);
    chk("lu_bubble", {31'b0, bubble_e}, 32'h1);
    tick();
    chk("lu_pending_held", pending_o, 32'h20);
    #1 chk("lu_stall_2", {31'b0, stall_d}, 32'h1);
    wb(1, 5);
    #1 chk("lu_bypass_stall", {31'b0, stall_d}, 32'h0);
    chk("lu_bypass_bubble", {31'b0, bubble_e}, 32'h0);
    tick();
    chk("lu_cleared", pending_o, 32'h0);
    idle_in();

    // 2. x0 destination
    d_instr(1, 0, 1, 0, 0, 0, 0, 0);          // lw x0
    tick();
    chk("x0_pending", pending_o, 32'h0);
    d_instr(1, 6, 0, 0, 1, 0, 0, 0);          // add reads x0
    #1 chk("x0_stall", {31'b0, stall_d}, 32'h0);
    tick();
    idle_in();

    // 3. MUL occupancy and back-to-back MUL
    d_instr(1, 7, 0, 1, 0, 0, 0, 0);          // mul x7
    #1 chk("mul7_issue_stall", {31'b0, stall_d}, 32'h0);
    tick();
    d_instr(1, 8, 0, 1, 0, 0, 0, 0);          // mul x8 waiting
    #1 chk("mul_busy_c1", {31'b0, mul_busy_e}, 32'h1);
    chk("mul_stall_c1", {31'b0, stall_d}, 32'h1);
    chk("mul_bubble_c1", {31'b0, bubble_e}, 32'h0);
    chk("mul7_pending", pending_o, 32'h80);
    tick();
    #1 chk("mul_busy_c2", {31'b0, mul_busy_e}, 32'h1);
    chk("mul_stall_c2", {31'b0, stall_d}, 32'h1);
    tick();
    #1 chk("mul_busy_c3", {31'b0, mul_busy_e}, 32'h0);
    chk("mul8_issue_stall", {31'b0, stall_d}, 32'h0);
    tick();
    chk("mul8_pending", pending_o, 32'h180);
    idle_in();
    wb(1, 7);
    #1 chk("mul8_busy", {31'b0, mul_busy_e}, 32'h1);
    tick();
    chk("mul7_cleared", pending_o, 32'h100);
    wb(1, 8);
    tick();
    chk("mul8_cleared", pending_o, 32'h0);
    chk("mul_idle_end", {31'b0, mul_busy_e}, 32'h0);
    idle_in();

    // 4. set/clear collision, rs2 hazard, unused source
    d_instr(1, 9, 1, 0, 0, 0, 0, 0);          // lw x9
    wb(1, 9);
    tick();
    chk("coll_pending", pending_o, 32'h200);
    idle_in();
    d_instr(0, 0, 0, 0, 0, 0, 1, 9);          // reads x9 via rs2
    #1 chk("rs2_stall", {31'b0, stall_d}, 32'h1);
    chk("rs2_bubble", {31'b0, bubble_e}, 32'h1);
    rs2_used_d = 0;
    #1 chk("rs2_unused_stall", {31'b0, stall_d}, 32'h0);
    issue_valid_d = 0; rs2_used_d = 1;
    #1 chk("no_issue_stall", {31'b0, stall_d}, 32'h0);
    idle_in();
    wb(1, 9);
    tick();
    chk("x9_cleared", pending_o, 32'h0);
    idle_in();

    // 5. flush
    d_instr(1, 3, 1, 0, 0, 0, 0, 0);          // lw x3 flushed
    flush_e = 1;
    tick();
    chk("flush_pending", pending_o, 32'h0);
    d_instr(1, 10, 0, 1, 0, 0, 0, 0);         // mul x10 flushed
    flush_e = 1;
    tick();
    chk("flush_mul_busy", {31'b0, mul_busy_e}, 32'h0);
    chk("flush_mul_pending", pending_o, 32'h0);
    idle_in();

    // 6. reset mid-MUL
    d_instr(1, 4, 0, 1, 0, 0, 0, 0);          // mul x4
    tick();
    idle_in();
    d_instr(0, 0, 0, 0, 1, 4, 0, 0);          // reads x4 while MUL busy
    #1 chk("mid_busy", {31'b0, mul_busy_e}, 32'h1);
    chk("mid_pending", pending_o, 32'h10);
    rst_n = 0;
    #1 chk("arst_pending", pending_o, 32'h0);
    chk("arst_busy", {31'b0, mul_busy_e}, 32'h0);
    chk("arst_stall", {31'b0, stall_d}, 32'h0);
    chk("arst_bubble", {31'b0, bubble_e}, 32'h0);
    idle_in();
    #1 rst_n = 1;
    tick();
    chk("post_rst_busy", {31'b0, mul_busy_e}, 32'h0);
    chk("post_rst_pending", pending_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
